// File: rtl/sync_pulse_sched_pkg.sv
// Purpose:      shared types and helpers for the pulse-synchronizer scheduler.
// Latency:      n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cobi_sync_pkg;

  // Scheduler FSM: idle, one-cycle pulse issue, then wait for ack high and low.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } sched_state_t;

  // Cycles allowed in the wait states before the timeout flag is raised.
  localparam int TIMEOUT_CYC_DFLT = 1024;

  // Next round-robin index after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sync_rr_arb.sv
// Purpose:      round-robin select over pending bits, search starting at ptr and wrapping.
// Latency:      combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is taken this cycle.
module sync_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [ID_W-1:0]  ptr,
  output logic             vld,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

  // Walk offsets from farthest to nearest so the one closest to ptr is kept last.
  always_comb begin
    int idx;
    vld     = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (pend[idx]) begin
        vld     = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    gnt[gnt_idx] = vld;
  end

endmodule

// File: rtl/sync_pulse_sched.sv
// Purpose:      shares one fast-to-slow pulse synchronizer between N_REQ requesters, round-robin.
// Latency:      req at edge E0 pends after E0; grant and sync_pulse at E1; done one edge after ack falls.
// Backpressure: one transfer in flight; further requests pend (merged, flagged in ovf) until granted.
module sync_pulse_sched
  import cobi_sync_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ID_W        = $clog2(N_REQ),
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
  input  logic             clk_fast,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  output logic             sync_pulse,
  input  logic             sync_ack,
  output logic [ID_W-1:0]  sync_tag,
  output logic [N_REQ-1:0] pend,
  output logic             busy,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] ovf,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TO_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);

  sched_state_t     state;
  logic [ID_W-1:0]  ptr;
  logic [TW-1:0]    tcnt;

  logic             arb_vld;
  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;

  logic             grant_fire;
  logic [N_REQ-1:0] grant_clr;
  logic [N_REQ-1:0] ovf_set;
  logic             waiting;
  logic             to_hit;

  sync_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .pend    (pend),
    .ptr     (ptr),
    .vld     (arb_vld),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Grant only from IDLE and never while the channel still shows ack high.
  always_comb begin
    grant_fire = (state == IDLE) && arb_vld && !sync_ack;
    grant_clr  = grant_fire ? arb_gnt : '0;
    ovf_set    = req & pend & ~grant_clr;
    waiting    = (state == WAIT_HI) || (state == WAIT_LO);
    to_hit     = waiting && (tcnt == TO_LAST);
  end

  assign busy = (state != IDLE);

  // Pending bits (a same-edge request re-arms a bit being granted) and sticky overflow.
  always_ff @(posedge clk_fast) begin
    if (!rstn) begin
      pend <= '0;
      ovf  <= '0;
    end else begin
      pend <= (pend & ~grant_clr) | req;
      ovf  <= (err_clr ? '0 : ovf) | ovf_set;
    end
  end

  // Handshake FSM: issue one-cycle pulse, wait ack high, wait ack low, then report done.
  always_ff @(posedge clk_fast) begin
    if (!rstn) begin
      state      <= IDLE;
      sync_pulse <= 1'b0;
      sync_tag   <= '0;
      done       <= '0;
      ptr        <= '0;
    end else begin
      sync_pulse <= 1'b0;
      done       <= '0;
      case (state)
        IDLE: begin
          if (grant_fire) begin
            sync_pulse <= 1'b1;
            sync_tag   <= arb_idx;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (sync_ack) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!sync_ack) begin
            done  <= N_REQ'(1) << sync_tag;
            ptr   <= ID_W'(rr_next(32'(sync_tag), N_REQ));
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Watchdog on the wait states: flags but never aborts, since a live handshake must finish.
  always_ff @(posedge clk_fast) begin
    if (!rstn) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        tcnt <= '0;
      end else if (waiting && (tcnt != TO_MAX)) begin
        tcnt <= tcnt + 1'b1;
      end
      timeout_err <= (err_clr ? 1'b0 : timeout_err) | to_hit;
    end
  end

endmodule

// File: tb/tb_sync_pulse_sched.sv
module tb_sync_pulse_sched;
  import cobi_sync_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 64;

  logic clk_fast = 1'b0;
  logic clk_slow = 1'b0;
  always #5  clk_fast = ~clk_fast;
  always #20 clk_slow = ~clk_slow;

  logic          rstn;
  logic [N-1:0]  req;
  logic          man_ack;
  logic          auto_mode;
  logic          err_clr;
  logic          sync_ack;
  logic          sync_pulse;
  logic [IW-1:0] sync_tag;
  logic [N-1:0]  pend;
  logic [N-1:0]  done;
  logic [N-1:0]  ovf;
  logic          busy;
  logic          timeout_err;

  // Four-phase pulse synchronizer model, 4:1 clock ratio, sharing rstn.
  logic req_lvl, s1, s2, s3, a1, a2;
  int   slow_cnt = 0;

  always @(posedge clk_fast) begin
    if (!rstn) begin
      req_lvl <= 1'b0; a1 <= 1'b0; a2 <= 1'b0;
    end else begin
      if (sync_pulse) req_lvl <= 1'b1;
      else if (a2)    req_lvl <= 1'b0;
      a1 <= s2;
      a2 <= a1;
    end
  end

  always @(posedge clk_slow) begin
    if (!rstn) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
    end else begin
      if (s2 && !s3) slow_cnt <= slow_cnt + 1;
      s1 <= req_lvl;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync_ack = auto_mode ? a2 : man_ack;

  sync_pulse_sched #(
    .N_REQ       (N),
    .ID_W        (IW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_fast    (clk_fast),
    .rstn        (rstn),
    .req         (req),
    .sync_pulse  (sync_pulse),
    .sync_ack    (sync_ack),
    .sync_tag    (sync_tag),
    .pend        (pend),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  typedef struct {
    logic          rstn;
    logic [N-1:0]  req;
    logic          ack;
    logic          clr;
    logic          pulse;
    logic [IW-1:0] tag;
    logic [N-1:0]  pend;
    logic          busy;
    logic [N-1:0]  done;
    logic [N-1:0]  ovf;
    logic          terr;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic [N-1:0] rq, input logic a, input logic c,
                     input logic p, input logic [IW-1:0] t, input logic [N-1:0] pd,
                     input logic b, input logic [N-1:0] d, input logic [N-1:0] o, input logic te);
    vec_t v;
    v.rstn = r; v.req = rq; v.ack = a; v.clr = c;
    v.pulse = p; v.tag = t; v.pend = pd; v.busy = b; v.done = d; v.ovf = o; v.terr = te;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_fast);
    #1;
  endtask

  initial begin
    int pulse_cnt, done_cnt, bad_busy, slow0;
    logic [IW-1:0] tag_seen;
    logic [N-1:0]  done_seen;

    rstn = 1'b0; req = '0; man_ack = 1'b0; auto_mode = 1'b0; err_clr = 1'b0;

    //   rstn req     ack clr | pulse tag pend    busy done    ovf     terr
    // reset, then 1011 granted 0,1,3
    add(0, 4'b0000, 0, 0,  0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b1011, 0, 0,  0, 0, 4'b1011, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  1, 0, 4'b1010, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 0, 4'b1010, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0,  0, 0, 4'b1010, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0,  0, 0, 4'b1010, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 0, 4'b1010, 0, 4'b0001, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  1, 1, 4'b1000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 1, 4'b1000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0,  0, 1, 4'b1000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 1, 4'b1000, 0, 4'b0010, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  1, 3, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 3, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0,  0, 3, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 3, 4'b0000, 0, 4'b1000, 4'b0000, 0);
    // ack held high in IDLE blocks a new issue
    add(1, 4'b0001, 1, 0,  0, 3, 4'b0001, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0,  0, 3, 4'b0001, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  1, 0, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 0, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0,  0, 0, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 0, 4'b0000, 0, 4'b0001, 4'b0000, 0);
    // grant 1, then 0011 arrives: 0 served after 1 (wrap), then 1
    add(1, 4'b0010, 0, 0,  0, 0, 4'b0010, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  1, 1, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0011, 0, 0,  0, 1, 4'b0011, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0,  0, 1, 4'b0011, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 1, 4'b0011, 0, 4'b0010, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  1, 0, 4'b0010, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0,  0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 0, 4'b0010, 0, 4'b0001, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  1, 1, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 1, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0,  0, 1, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 1, 4'b0000, 0, 4'b0010, 4'b0000, 0);
    // overflow on requester 2, merged into a single transfer
    add(1, 4'b0001, 0, 0,  0, 1, 4'b0001, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0100, 0, 0,  1, 0, 4'b0100, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0100, 0, 0,  0, 0, 4'b0100, 1, 4'b0000, 4'b0100, 0);
    add(1, 4'b0100, 0, 0,  0, 0, 4'b0100, 1, 4'b0000, 4'b0100, 0);
    add(1, 4'b0000, 1, 0,  0, 0, 4'b0100, 1, 4'b0000, 4'b0100, 0);
    add(1, 4'b0000, 0, 0,  0, 0, 4'b0100, 0, 4'b0001, 4'b0100, 0);
    add(1, 4'b0000, 0, 0,  1, 2, 4'b0000, 1, 4'b0000, 4'b0100, 0);
    add(1, 4'b0000, 0, 0,  0, 2, 4'b0000, 1, 4'b0000, 4'b0100, 0);
    add(1, 4'b0000, 1, 0,  0, 2, 4'b0000, 1, 4'b0000, 4'b0100, 0);
    add(1, 4'b0000, 0, 0,  0, 2, 4'b0000, 0, 4'b0100, 4'b0100, 0);
    add(1, 4'b0000, 0, 0,  0, 2, 4'b0000, 0, 4'b0000, 4'b0100, 0);
    add(1, 4'b0000, 0, 1,  0, 2, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    // overflow set in the same cycle as err_clr: set wins
    add(1, 4'b0100, 1, 0,  0, 2, 4'b0100, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0100, 1, 1,  0, 2, 4'b0100, 0, 4'b0000, 4'b0100, 0);
    add(1, 4'b0000, 1, 1,  0, 2, 4'b0100, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  1, 2, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 2, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0,  0, 2, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 2, 4'b0000, 0, 4'b0100, 4'b0000, 0);
    // reset during WAIT_LO, then requester 2 completes from a fresh pointer
    add(1, 4'b1000, 0, 0,  0, 2, 4'b1000, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  1, 3, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 3, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0,  0, 3, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 1, 0,  0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0100, 0, 0,  0, 0, 4'b0100, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  1, 2, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 2, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0,  0, 2, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,  0, 2, 4'b0000, 0, 4'b0100, 4'b0000, 0);

    for (int i = 0; i < vq.size(); i++) begin
      rstn = vq[i].rstn; req = vq[i].req; man_ack = vq[i].ack; err_clr = vq[i].clr;
      step();
      chk($sformatf("vec%0d {pulse,tag,pend,busy,done,ovf,terr}", i),
          32'({sync_pulse, sync_tag, pend, busy, done, ovf, timeout_err}),
          32'({vq[i].pulse, vq[i].tag, vq[i].pend, vq[i].busy, vq[i].done, vq[i].ovf, vq[i].terr}));
    end
    rstn = 1'b1; req = '0; man_ack = 1'b0; err_clr = 1'b0;

    // Timeout: ack stuck low, pointer is 3 so requester 0 is next.
    req = 4'b0001; step();
    req = '0;      step();
    chk("to_issue_tag", 32'(sync_tag), 32'd0);
    step();
    chk("to_enter_waithi", 32'(dut.state), 32'(WAIT_HI));
    for (int k = 1; k <= TO; k++) begin
      step();
      if (k == TO - 1) chk("to_before_limit", 32'(timeout_err), 32'd0);
      if (k == TO)     chk("to_at_limit", 32'(timeout_err), 32'd1);
    end
    repeat (5) step();
    chk("to_still_waithi", 32'(dut.state), 32'(WAIT_HI));
    chk("to_sticky_busy", 32'({timeout_err, busy}), 32'b11);
    man_ack = 1'b1; step();
    chk("to_waitlo", 32'(dut.state), 32'(WAIT_LO));
    man_ack = 1'b0; step();
    chk("to_done", 32'({done, timeout_err, busy}), 32'b0001_1_0);
    err_clr = 1'b1; step();
    err_clr = 1'b0;
    chk("to_clear", 32'(timeout_err), 32'd0);

    // Real synchronizer model at 4:1: one request end to end.
    auto_mode = 1'b1;
    rstn = 1'b0; repeat (12) step();
    rstn = 1'b1; repeat (2) step();
    chk("sync_reset_idle", 32'({sync_pulse, busy, done, pend, sync_ack}), 32'd0);
    slow0 = slow_cnt;
    pulse_cnt = 0; done_cnt = 0; bad_busy = 0; tag_seen = '1; done_seen = '0;
    req = 4'b0001; step();
    req = '0;
    for (int c = 0; c < 300; c++) begin
      if (sync_pulse) begin pulse_cnt++; tag_seen = sync_tag; end
      if (done != '0) begin done_cnt++; done_seen = done; end
      if (sync_ack && !busy) bad_busy++;
      step();
    end
    chk("sync_pulse_count", 32'(pulse_cnt), 32'd1);
    chk("sync_tag", 32'(tag_seen), 32'd0);
    chk("sync_done_count", 32'(done_cnt), 32'd1);
    chk("sync_done_bits", 32'(done_seen), 32'b0001);
    chk("sync_slow_pulses", 32'(slow_cnt - slow0), 32'd1);
    chk("sync_busy_while_ack", 32'(bad_busy), 32'd0);
    chk("sync_final_idle", 32'({busy, sync_ack, pend}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_pulse_sched.md
Name: sync_pulse_sched

Overview:
- Fast-domain scheduler that shares one fast-to-slow pulse-synchronizer channel between N requesters.
- Latches incoming request pulses and grants them round-robin.
- Drives the channel's single-cycle pulse input and follows its request/ack handshake to completion.
- Holds a quasi-static tag (the requester ID), stable for the whole transfer, so the slow side can sample it safely on the synchronized pulse.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), tag width.
- TIMEOUT_CYC, 1024, clk_fast cycles allowed in the wait states before timeout_err is flagged.

Ports:
- clk_fast  in  1  fast clock; the only clock.
- rstn  in  1  synchronous, active-low reset.
- req  in  N_REQ  one-cycle request pulses, one bit per requester.
- sync_pulse  out  1  to the synchronizer's fast_pulse input.
- sync_ack  in  1  from the synchronizer's slow_sync_ack output, already synchronized to clk_fast.
- sync_tag  out  ID_W  ID of the transfer in flight.
- pend  out  N_REQ  pending-request bits.
- busy  out  1  a transfer is in flight.
- done  out  N_REQ  one-cycle completion pulse, one bit per requester.
- ovf  out  N_REQ  sticky flag: request merged into an already-pending one.
- timeout_err  out  1  sticky flag: handshake exceeded TIMEOUT_CYC.
- err_clr  in  1  clears ovf and timeout_err.

Behaviour:
- Reset: rstn is sampled on the clk_fast edge only. All outputs, pend, state, RR pointer and timeout counter reset to 0. State resets to IDLE.
- Reset mid-transfer: the scheduler abandons the transfer. The synchronizer shares rstn and clears too.
- Pending: at every edge, pend[i] <= (pend[i] & ~grant_clr[i]) | req[i]. A req on the same edge its own bit is granted re-sets pend[i]: req wins.
- Overflow: req[i] while pend[i]=1 and not being cleared that edge sets ovf[i]. The request is merged, not queued.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
  - IDLE: if pend is non-zero, the RR arbiter selects index g. At that edge: pend[g] cleared, sync_tag<=g, sync_pulse<=1, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: sync_pulse<=0 (high for exactly one cycle). Go to WAIT_HI.
  - WAIT_HI: when sync_ack=1, go to WAIT_LO.
  - WAIT_LO: when sync_ack=0, done[sync_tag]<=1 for one cycle, RR pointer<=g+1 mod N_REQ, go to IDLE.
- A new grant is possible on the edge after returning to IDLE. The scheduler never issues while sync_ack=1.
- busy=1 in ISSUE, WAIT_HI and WAIT_LO.
- sync_tag is held constant from ISSUE until the cycle after done.
- Round-robin: search starts at the pointer and wraps. The pointer starts at 0.
- Latency: req at edge E0 sets pend after E0. Grant happens at E1, and sync_pulse is high between E1 and E2.
- Timeout counter:
  - Counts clk_fast cycles in WAIT_HI+WAIT_LO; cleared on entering ISSUE.
  - When it reaches TIMEOUT_CYC, sets timeout_err and saturates.
  - The FSM does not abort; it keeps waiting, because abandoning a live handshake corrupts the channel.
- err_clr clears ovf and timeout_err at the edge. A set event in the same cycle wins.
- sync_ack is used directly; the scheduler adds no further synchronization.

Decomposition:
- Package cobi_sync_pkg:
  - state enum sched_state_t {IDLE, ISSUE, WAIT_HI, WAIT_LO}.
  - Default TIMEOUT_CYC constant.
  - Helper function for the wrapped RR index increment.
- Sub-module sync_rr_arb: combinational round-robin select.
  - Inputs: pend, pointer.
  - Outputs: valid, one-hot grant, grant index.

Test Plan:
1. Reset, then req=0001 once, with the real synchronizer attached at a 4:1 clock ratio -> one sync_pulse cycle, sync_tag=0, busy high until ack falls, done=0001 for one cycle, exactly one slow_pulse observed.
2. req=1011 in one cycle -> grants in order 0, 1, 3. Each sync_pulse issues only after sync_ack returns low. done pulses appear in the same order, and pend shrinks 1011→1010→1000→0000.
3. After a grant of 1, pulse req=0011 -> next grant is 0 only after 1 completes. The pointer then moves to 1, and the RR wrap is confirmed.
4. req[2] pulsed twice while pend[2]=1 -> ovf=0100, only one transfer for requester 2; err_clr returns ovf to 0.
5. Model sync_ack stuck at 0 -> timeout_err=1 exactly TIMEOUT_CYC cycles after entering WAIT_HI, FSM remains in WAIT_HI. Releasing ack high then low completes the transfer normally.
6. Assert rstn=0 for one edge during WAIT_LO -> next cycle all outputs are 0 and state is IDLE. A new req=0100 completes normally with tag=2.
